// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback path.
package wb_pkg;

  // Default datapath width and architectural register count.
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 16;

  // Register index width (16 architectural registers).
  localparam int REG_W = 4;

  // One pending long-latency result: destination plus bit-exact payload.
  typedef struct packed {
    logic [REG_W-1:0]        rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries. The head is visible
// combinationally so the arbiter can pop and register it in one edge.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is tiny, so it lives in flops and the head read is combinational.
  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO never accepts a push, even if it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign cnt     = count;

  // Write the incoming entry at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Advance pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and queued LSU results onto the single register-file write
// port and tracks per-register pending long-latency writes.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREG  = NREG_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_W-1:0]       alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [REG_W-1:0]       lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  input  logic                   iss_valid,
  input  logic [REG_W-1:0]       iss_rd,
  output logic [NREG-1:0]        busy,
  output logic                   rf_we,
  output logic [REG_W-1:0]       rf_rd,
  output logic [XLEN-1:0]        rf_wd,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  // The entry struct carries XLEN_DEFAULT bits of data; XLEN must match it.

  wb_entry_t        head;
  wb_entry_t        lsu_entry;
  wb_entry_t        win_entry;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             win;

  logic [NREG-1:0]  busy_reg;
  logic [NREG-1:0]  busy_next;
  logic [NREG-1:0]  set_mask;
  logic [NREG-1:0]  clr_mask;

  logic             rf_we_reg;
  logic [REG_W-1:0] rf_rd_reg;
  logic [XLEN-1:0]  rf_wd_reg;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

  // Both handshakes depend only on occupancy, never on the valids.
  assign lsu_ready = !full;
  assign alu_ready = !full;
  assign push      = lsu_valid && !full;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (lsu_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .cnt        (fifo_cnt)
  );

  // Pick the write-port owner: a full FIFO first, then ALU, then any queued entry.
  always_comb begin
    pop       = 1'b0;
    win       = 1'b0;
    win_entry = '0;
    if (full) begin
      pop       = 1'b1;
      win       = 1'b1;
      win_entry = head;
    end else if (alu_valid) begin
      win       = 1'b1;
      win_entry = '{rd: alu_rd, data: alu_data};
    end else if (!empty) begin
      pop       = 1'b1;
      win       = 1'b1;
      win_entry = head;
    end
  end

  // Per-register set on issue and clear on a popped writeback; r0 never goes busy.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign set_mask[gi] = 1'b0;
        assign clr_mask[gi] = 1'b0;
      end else begin : g_reg
        assign set_mask[gi] = iss_valid && (iss_rd == REG_W'(gi));
        assign clr_mask[gi] = pop && (head.rd == REG_W'(gi));
      end
    end
  endgenerate

  // Set is applied after clear so a same-cycle reissue keeps the bit high.
  assign busy_next = (busy_reg & ~clr_mask) | set_mask;

  // Register the write port; writes to r0 are consumed but never enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_reg <= 1'b0;
      rf_rd_reg <= '0;
      rf_wd_reg <= '0;
    end else begin
      rf_we_reg <= win && (win_entry.rd != '0);
      if (win) begin
        rf_rd_reg <= win_entry.rd;
        rf_wd_reg <= win_entry.data;
      end
    end
  end

  // Scoreboard update shares the write-port edge so busy drops with rf_we.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy  = busy_reg;
  assign rf_we = rf_we_reg;
  assign rf_rd = rf_rd_reg;
  assign rf_wd = rf_wd_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: linear stimulus with hand-computed expectations.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [3:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        iss_valid;
  logic [3:0]  iss_rd;
  logic [15:0] busy;
  logic        rf_we;
  logic [3:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [1:0]  fifo_cnt;

  int errors = 0;
  int checks = 0;

  writeback_unit #(.XLEN(32), .NREG(16), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0; iss_valid = 0; iss_rd = 0;
    step(); step();
    // Reset state
    chk("rst_we", rf_we, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_lsu_ready", lsu_ready, 1);
    rst_n = 1'b1;
    step();

    // Single ALU write: one-cycle latency, one-cycle pulse
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    chk("alu_ready_idle", alu_ready, 1);
    step();
    alu_valid = 0;
    chk("alu_we", rf_we, 1);
    chk("alu_rd", rf_rd, 5);
    chk("alu_wd", rf_wd, 32'hDEADBEEF);
    chk("alu_busy", busy, 0);
    chk("alu_cnt", fifo_cnt, 0);
    step();
    chk("alu_we_pulse", rf_we, 0);

    // Issue to r3, then LSU result for r3: two-cycle latency and busy clear
    iss_valid = 1; iss_rd = 3;
    step();
    iss_valid = 0;
    chk("iss3_busy", busy, 16'h0008);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h1234;
    step();
    lsu_valid = 0;
    chk("lsu3_cnt1", fifo_cnt, 1);
    chk("lsu3_we_wait", rf_we, 0);
    chk("lsu3_busy_wait", busy, 16'h0008);
    step();
    chk("lsu3_we", rf_we, 1);
    chk("lsu3_rd", rf_rd, 3);
    chk("lsu3_wd", rf_wd, 32'h1234);
    chk("lsu3_busy_clr", busy, 0);
    chk("lsu3_cnt0", fifo_cnt, 0);
    step();
    chk("lsu3_we_pulse", rf_we, 0);

    // ALU priority while the FIFO fills, then the full FIFO takes the port
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA0;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    step();
    chk("fill_cnt1", fifo_cnt, 1);
    chk("fill_alu0_rd", rf_rd, 10);
    chk("fill_alu0_wd", rf_wd, 32'hA0);
    alu_data = 32'hA1; lsu_rd = 8; lsu_data = 32'h88;
    step();
    lsu_valid = 0; alu_data = 32'hA2;
    chk("fill_cnt2", fifo_cnt, 2);
    chk("fill_alu1_wd", rf_wd, 32'hA1);
    chk("full_lsu_ready", lsu_ready, 0);
    chk("full_alu_ready", alu_ready, 0);
    step();
    chk("drain7_we", rf_we, 1);
    chk("drain7_rd", rf_rd, 7);
    chk("drain7_wd", rf_wd, 32'h77);
    chk("drain7_cnt", fifo_cnt, 1);
    chk("drain7_alu_ready", alu_ready, 1);
    alu_valid = 0;
    step();
    chk("drain8_rd", rf_rd, 8);
    chk("drain8_wd", rf_wd, 32'h88);
    chk("drain8_cnt", fifo_cnt, 0);
    alu_valid = 1; alu_data = 32'hA3;
    step();
    alu_valid = 0;
    chk("resume_we", rf_we, 1);
    chk("resume_rd", rf_rd, 10);
    chk("resume_wd", rf_wd, 32'hA3);
    step();
    chk("resume_we_pulse", rf_we, 0);

    // Writes to r0 from ALU and LSU never enable; busy untouched
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    iss_valid = 1; iss_rd = 6;
    chk("r0_alu_ready", alu_ready, 1);
    step();
    alu_valid = 0; iss_rd = 0;
    chk("r0_alu_we", rf_we, 0);
    chk("r0_alu_busy", busy, 16'h0040);
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h55;
    step();
    lsu_valid = 0; iss_valid = 0;
    chk("r0_lsu_cnt", fifo_cnt, 1);
    chk("r0_iss_busy", busy, 16'h0040);
    step();
    chk("r0_lsu_we", rf_we, 0);
    chk("r0_lsu_cnt0", fifo_cnt, 0);
    chk("r0_lsu_busy", busy, 16'h0040);
    lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h66;
    step();
    lsu_valid = 0;
    step();
    chk("r6_rd", rf_rd, 6);
    chk("r6_busy_clr", busy, 0);

    // Same-cycle reissue and pop of r4: write happens, set wins
    iss_valid = 1; iss_rd = 4;
    step();
    iss_valid = 0;
    chk("iss4_busy", busy, 16'h0010);
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
    step();
    lsu_valid = 0;
    iss_valid = 1; iss_rd = 4;
    step();
    iss_valid = 0;
    chk("race4_we", rf_we, 1);
    chk("race4_rd", rf_rd, 4);
    chk("race4_wd", rf_wd, 32'h44);
    chk("race4_busy", busy, 16'h0010);

    // Reset mid-operation flushes FIFO and scoreboard
    iss_valid = 1; iss_rd = 9;
    step();
    iss_valid = 0;
    alu_valid = 1; alu_rd = 11; alu_data = 32'hB0;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    step();
    lsu_rd = 12; lsu_data = 32'hC0;
    step();
    alu_valid = 0; lsu_valid = 0;
    chk("prerst_cnt", fifo_cnt, 2);
    chk("prerst_busy", busy, 16'h0210);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_cnt", fifo_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_we", rf_we, 0);
    chk("midrst_alu_ready", alu_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("postrst_we_%0d", i), rf_we, 0);
      chk($sformatf("postrst_cnt_%0d", i), fifo_cnt, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
